// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the I2C byte master.
//   i2c_state_t     - transaction FSM state encoding
//   I2C_QTR_DEFAULT - default clk cycles per SCL quarter-period
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    ACK   = 3'd3,
    STOP  = 3'd4
  } i2c_state_t;

  localparam int unsigned I2C_QTR_DEFAULT = 8;

endpackage

// File: rtl/scl_quarter_timer.sv
// scl_quarter_timer: SCL quarter-period down-counter.
// Ports:
//   clk, rst  - system clock, async active-high reset
//   run       - high while a transaction is in progress
//   stall     - freezes the counter (clock stretching)
//   qtr_tick  - high on the last clk of each quarter
//   qtr       - quarter index within the current SCL period (0..3)
// While idle the timer preloads qtr=2 so that the two START quarters
// line up with the SCL-high half (q2, q3) and DATA begins at q0.
module scl_quarter_timer
  import i2c_pkg::*;
#(
  parameter int unsigned QTR_CYCLES = I2C_QTR_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       stall,
  output logic       qtr_tick,
  output logic [1:0] qtr
);

  localparam logic [7:0] CNT_LOAD = 8'(QTR_CYCLES - 1);

  logic [7:0] cnt;

  assign qtr_tick = run && !stall && (cnt == 8'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 8'd0;
      qtr <= 2'd0;
    end else if (!run) begin
      cnt <= CNT_LOAD;
      qtr <= 2'd2;
    end else if (!stall) begin
      if (cnt == 8'd0) begin
        cnt <= CNT_LOAD;
        qtr <= qtr + 2'd1;
      end else begin
        cnt <= cnt - 8'd1;
      end
    end
  end

endmodule

// File: rtl/i2c_byte_master.sv
// i2c_byte_master: sends one byte on I2C (START, 8 data bits MSB first,
// ACK sample, STOP) per accepted start request.
// Ports:
//   clk, rst         - system clock, async active-high reset
//   start, tx_byte   - transaction request and byte to send
//   sda_in, scl_in   - synchronized bus line values
//   scl_out, sda_out - open-drain drives (0 pulls low, 1 releases)
//   busy, done       - in-progress flag, one-cycle completion pulse
//   ack_err          - NACK seen, held until the next accepted start
// Optional build macro: I2C_CLOCK_STRETCH_EN (freeze timing while a
// released SCL is held low by the slave).
//
// state | meaning
// IDLE  | bus released, waiting for start
// START | SDA low while SCL high, 2 quarters
// DATA  | 8 bits, 4 quarters each; SDA changes only at SCL fall
// ACK   | SDA released, slave ACK sampled at end of q2
// STOP  | SCL low/high with SDA low, then SDA rises while SCL high
module i2c_byte_master
  import i2c_pkg::*;
#(
  parameter int unsigned QTR_CYCLES = I2C_QTR_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       sda_in,
  input  logic       scl_in,
  output logic       scl_out,
  output logic       sda_out,
  output logic       busy,
  output logic       done,
  output logic       ack_err
);

  i2c_state_t state;
  logic [7:0] data;
  logic [2:0] bit_idx;
  logic       qtr_tick;
  logic [1:0] qtr;
  logic [1:0] qtr_next;
  logic       stall;

`ifdef I2C_CLOCK_STRETCH_EN
  assign stall = scl_out && !scl_in;
`else
  logic scl_in_unused;
  assign scl_in_unused = scl_in;
  assign stall = 1'b0;
`endif

  assign qtr_next = qtr + 2'd1;

  scl_quarter_timer #(.QTR_CYCLES(QTR_CYCLES)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .run      (state != IDLE),
    .stall    (stall),
    .qtr_tick (qtr_tick),
    .qtr      (qtr)
  );

  // Outputs are assigned on the tick that enters a quarter, so they are
  // registered and take the new quarter's value on its first cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      scl_out <= 1'b1;
      sda_out <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
      bit_idx <= 3'd0;
      data    <= 8'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= START;
            busy    <= 1'b1;
            data    <= tx_byte;
            ack_err <= 1'b0;
            sda_out <= 1'b0;
          end
        end
        START: begin
          if (qtr_tick && qtr == 2'd3) begin
            state   <= DATA;
            bit_idx <= 3'd7;
            scl_out <= 1'b0;
            sda_out <= data[7];
          end
        end
        DATA: begin
          if (qtr_tick) begin
            scl_out <= qtr_next[1];
            if (qtr == 2'd3) begin
              bit_idx <= bit_idx - 3'd1;
              if (bit_idx == 3'd0) begin
                state   <= ACK;
                sda_out <= 1'b1;
              end else begin
                sda_out <= data[bit_idx - 3'd1];
              end
            end
          end
        end
        ACK: begin
          if (qtr_tick) begin
            scl_out <= qtr_next[1];
            if (qtr == 2'd2) ack_err <= sda_in;
            if (qtr == 2'd3) begin
              state   <= STOP;
              sda_out <= 1'b0;
            end
          end
        end
        STOP: begin
          if (qtr_tick) begin
            case (qtr)
              2'd0: begin
                scl_out <= 1'b1;
                sda_out <= 1'b0;
              end
              2'd1: begin
                scl_out <= 1'b1;
                sda_out <= 1'b1;
              end
              2'd2: ;
              default: begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
